// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: state encoding and
// default parameter values.
package ram_access_ctrl_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_TICK_DIV = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_CAP,
    SCAN_WAIT,
    SCAN_RD,
    SCAN_CAP
  } state_t;

  // Counter width able to hold div-1, never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_tick.sv
// Scan step divider: counts enabled cycles and pulses tc on the last one of
// each TICK_DIV-cycle period.
module tick_gen
  import ram_access_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = cnt_width(TICK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tc = enable && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || tc) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Push-button driven single-word RAM read/write controller with a slow
// auto-scan mode that walks every address onto the display.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              key,
  input  logic              wr_mode,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy
);

  state_t            state;
  logic              key_d;
  logic              press;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] scan_ptr;
  logic              tick_clr;
  logic              tick_en;
  logic              tick_tc;

  assign press    = key && !key_d;
  assign tick_clr = (state == IDLE);
  assign tick_en  = (state == SCAN_WAIT);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .clear  (tick_clr),
    .enable (tick_en),
    .tc     (tick_tc)
  );

  // RAM-facing outputs are loaded on entry to a state so they are valid for
  // the whole cycle the state is active; the RAM then returns data one cycle
  // later, which the *_CAP states pick up.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      key_d     <= 1'b1;
      addr_reg  <= '0;
      data_reg  <= '0;
      scan_ptr  <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_wren  <= 1'b0;
      disp_addr <= '0;
      disp_data <= '0;
      busy      <= 1'b0;
    end else begin
      key_d <= key;
      case (state)
        IDLE: begin
          if (press) begin
            addr_reg <= sw_addr;
            data_reg <= sw_data;
            ram_addr <= sw_addr;
            busy     <= 1'b1;
            if (wr_mode) begin
              ram_din  <= sw_data;
              ram_wren <= 1'b1;
              state    <= WRITE;
            end else begin
              state <= RD_ADDR;
            end
          end else if (scan_en) begin
            busy  <= 1'b1;
            state <= SCAN_WAIT;
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
          state    <= RD_ADDR;
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP: begin
          disp_data <= ram_dout;
          disp_addr <= addr_reg;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        SCAN_WAIT: begin
          if (!scan_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick_tc) begin
            ram_addr <= scan_ptr;
            state    <= SCAN_RD;
          end
        end
        SCAN_RD: state <= SCAN_CAP;
        SCAN_CAP: begin
          disp_data <= ram_dout;
          disp_addr <= scan_ptr;
          scan_ptr  <= scan_ptr + 1'b1;
          state     <= SCAN_WAIT;
        end
        default: begin
          ram_wren <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (2^ADDR_W words).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter TICK_DIV, default 50_000_000, clock cycles per scan step.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; ports as follows.
REQ-005 clock  input  1  system clock, all logic on its rising edge.
REQ-006 resetn  input  1  synchronous active-low reset.
REQ-007 key  input  1  debounced push-button level, 1 = pressed.
REQ-008 wr_mode  input  1  1 = press performs write then read-back; 0 = press performs read.
REQ-009 scan_en  input  1  1 = auto-scan all addresses.
REQ-010 sw_addr  input  ADDR_W  user address.
REQ-011 sw_data  input  DATA_W  user write data.
REQ-012 ram_addr  output  ADDR_W  RAM address.
REQ-013 ram_din  output  DATA_W  RAM write data.
REQ-014 ram_wren  output  1  RAM write enable.
REQ-015 ram_dout  input  DATA_W  RAM read data, valid one cycle after ram_addr is presented.
REQ-016 disp_addr  output  ADDR_W  address of last captured word.
REQ-017 disp_data  output  DATA_W  last captured word, drives the hex display.
REQ-018 busy  output  1  1 whenever state is not IDLE.

Function
REQ-019 The block SHALL register key into key_d each cycle; press = key AND NOT key_d (single-cycle pulse per rising edge).
REQ-020 States: IDLE, WRITE, RD_ADDR, RD_CAP, SCAN_WAIT, SCAN_RD, SCAN_CAP.
REQ-021 IDLE + press: latch sw_addr to addr_reg and sw_data to data_reg; go WRITE if wr_mode=1, else RD_ADDR.
REQ-022 IDLE + no press + scan_en=1: go SCAN_WAIT with tick counter cleared; press has priority over scan_en in the same cycle.
REQ-023 WRITE: ram_addr=addr_reg, ram_din=data_reg, ram_wren=1 for exactly one cycle; next RD_ADDR.
REQ-024 RD_ADDR: ram_addr=addr_reg, ram_wren=0; next RD_CAP.
REQ-025 RD_CAP: disp_data<=ram_dout, disp_addr<=addr_reg; next IDLE.
REQ-026 Latency: press to disp_data update is 2 cycles (read) or 3 cycles (write mode, display shows read-back value).
REQ-027 Changes to sw_addr/sw_data/wr_mode after the press cycle SHALL NOT affect the operation in progress.
REQ-028 SCAN_WAIT: counter increments each cycle; at TICK_DIV-1, clear counter and go SCAN_RD; if scan_en=0, go IDLE immediately.
REQ-029 SCAN_RD: ram_addr=scan_ptr; next SCAN_CAP.
REQ-030 SCAN_CAP: disp_data<=ram_dout, disp_addr<=scan_ptr; scan_ptr increments, wrapping 2^ADDR_W-1 to 0; next SCAN_WAIT.
REQ-031 Presses in any non-IDLE state SHALL be dropped, not queued.
REQ-032 ram_wren SHALL be 0 in every state except WRITE.
REQ-033 scan_ptr SHALL persist across scan exit/entry (resume, not restart).

Reset
REQ-034 resetn=0 at a rising clock edge: state IDLE, ram_addr=0, ram_din=0, ram_wren=0, disp_addr=0, disp_data=0, busy=0, scan_ptr=0, counter=0, addr_reg=0, data_reg=0.
REQ-035 key_d SHALL reset to 1 so a key held through reset produces no press.
REQ-036 Reset mid-operation (including during WRITE) SHALL abort with ram_wren=0 on the next cycle and no display update.

Structure
REQ-037 State enumeration and default parameter values SHALL live in a shared package.
REQ-038 The scan tick divider SHALL be one sub-module, tick_gen (clear, enable, TICK_DIV parameter, terminal-count pulse).

Verification (ADDR_W=4, DATA_W=8, TICK_DIV=4, 1-cycle-latency RAM model)
REQ-039 wr_mode=1, sw_addr=5, sw_data=0xA3, press -> one cycle ram_wren=1, addr 5, din 0xA3; 3 cycles after press disp_addr=5, disp_data=0xA3, busy low next cycle.
REQ-040 wr_mode=0, sw_addr=5, press, sw_addr changed to 7 the next cycle -> ram_wren stays 0; disp_data=0xA3, disp_addr=5 after 2 cycles.
REQ-041 Key held high 20 cycles -> exactly one operation; second press while busy -> dropped.
REQ-042 Preload addr n with n*0x11, scan_en=1 for 100 cycles -> disp_addr steps 0,1,...,15,0,... one step per 6 cycles, disp_data=disp_addr*0x11, ram_wren never 1.
REQ-043 resetn=0 during WRITE cycle with key held -> all outputs 0 next cycle, no press after release of reset.
REQ-044 press and scan_en=1 in same IDLE cycle -> single read/write performed first, then scan entered from IDLE.
